key_extract_sched: RTL

- Sits directly upstream of a stage's key extractor and sequences PHVs into it.
- Holds the per-VLAN key-offset/key-mask configuration table and buffers incoming PHVs in a small FIFO.
- Issues each PHV together with its looked-up offset and mask, spaced so the extractor's two-cycle IDLE/CYCLE_1 loop never drops a PHV.
- The table is configured through a simple write port, filtered by stage.

---
 rtl/key_extract_sched_if.sv | 31 +++
 rtl/key_extract_sched.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/key_extract_sched_if.sv
// PHV stream bundle around key_extract_sched.
//   Upstream side : phv_in, vlan_in, phv_valid_in -> ready_out
//   Downstream    : phv_out, phv_valid_out, key_offset_valid, key_offset_w,
//                   key_mask_w -> ready_in
// slave  = the scheduler's view, master = the surrounding pipeline's view.
interface key_extract_sched_if #(
  parameter int PHV_LEN        = 48*8+32*8+16*8+256,
  parameter int KEY_LEN        = 48*2+32*2+16*2+1,
  parameter int KEY_OFF        = (3+3)*3+20,
  parameter int C_VLANID_WIDTH = 12
);
  logic [PHV_LEN-1:0]        phv_in;
  logic [C_VLANID_WIDTH-1:0] vlan_in;
  logic                      phv_valid_in;
  logic                      ready_out;
  logic                      ready_in;
  logic [PHV_LEN-1:0]        phv_out;
  logic                      phv_valid_out;
  logic                      key_offset_valid;
  logic [KEY_OFF-1:0]        key_offset_w;
  logic [KEY_LEN-1:0]        key_mask_w;

  modport slave (
    input  phv_in, vlan_in, phv_valid_in, ready_in,
    output ready_out, phv_out, phv_valid_out, key_offset_valid, key_offset_w, key_mask_w
  );
  modport master (
    output phv_in, vlan_in, phv_valid_in, ready_in,
    input  ready_out, phv_out, phv_valid_out, key_offset_valid, key_offset_w, key_mask_w
  );
endinterface

// File: rtl/key_extract_sched.sv
// key_extract_sched: buffers PHVs in a small FIFO, looks up the per-VLAN
// key offset/mask and issues one PHV every other cycle at most so the
// downstream two-cycle key extractor never misses one.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   bus (slave)     PHV in/out stream, see key_extract_sched_if
//   cfg_*           table write port, applied only when cfg_stage == STAGE_ID
//   overflow_err    sticky, set when a PHV arrives while the FIFO is full
module key_extract_sched #(
  parameter int PHV_LEN            = 48*8+32*8+16*8+256,
  parameter int KEY_LEN            = 48*2+32*2+16*2+1,
  parameter int KEY_OFF            = (3+3)*3+20,
  parameter int KEY_OFF_ADDR_WIDTH = 4,
  parameter int C_VLANID_WIDTH     = 12,
  parameter int STAGE_ID           = 0,
  parameter int FIFO_DEPTH_LOG2    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  key_extract_sched_if.slave            bus,
  input  logic                          cfg_wr_en,
  input  logic [4:0]                    cfg_stage,
  input  logic [KEY_OFF_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [KEY_OFF-1:0]            cfg_key_off,
  input  logic [KEY_LEN-1:0]            cfg_key_mask,
  output logic                          overflow_err
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int TBL_N = 1 << KEY_OFF_ADDR_WIDTH;
  localparam int PTR_W = FIFO_DEPTH_LOG2;
  localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic {IDLE, GAP} state_e;
  typedef logic [KEY_OFF_ADDR_WIDTH-1:0] idx_t;

  // FIFO storage is not reset: count/pointers alone define what is valid.
  logic [PHV_LEN-1:0] fifo_phv [DEPTH];
  idx_t               fifo_idx [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
  logic [KEY_OFF-1:0] key_off_q, key_off_d;
  logic [KEY_LEN-1:0] key_mask_q, key_mask_d;
  logic               overflow_q, overflow_d;
  logic [KEY_OFF-1:0] tbl_off_q  [TBL_N];
  logic [KEY_OFF-1:0] tbl_off_d  [TBL_N];
  logic [KEY_LEN-1:0] tbl_mask_q [TBL_N];
  logic [KEY_LEN-1:0] tbl_mask_d [TBL_N];

  logic ready_out, push, pop, cfg_hit, bypass;
  idx_t head_idx;

  assign ready_out = (count_q != CNT_W'(DEPTH));
  assign push      = bus.phv_valid_in & ready_out;
  // Pop only from IDLE: the following GAP cycle is what spaces issues apart.
  assign pop       = (state_q == IDLE) & (count_q != '0) & bus.ready_in;
  assign head_idx  = fifo_idx[rd_ptr_q];
  assign cfg_hit   = cfg_wr_en & (cfg_stage == 5'(STAGE_ID));
  // Same-cycle write to the entry being looked up: the popped PHV sees new data.
  assign bypass    = cfg_hit & (cfg_addr == head_idx);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    valid_d    = 1'b0;
    phv_out_d  = phv_out_q;
    key_off_d  = key_off_q;
    key_mask_d = key_mask_q;
    overflow_d = overflow_q | (bus.phv_valid_in & ~ready_out);
    tbl_off_d  = tbl_off_q;
    tbl_mask_d = tbl_mask_q;
    if (cfg_hit) begin
      tbl_off_d[cfg_addr]  = cfg_key_off;
      tbl_mask_d[cfg_addr] = cfg_key_mask;
    end
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      IDLE: if (pop) begin
        state_d    = GAP;
        valid_d    = 1'b1;
        phv_out_d  = fifo_phv[rd_ptr_q];
        key_off_d  = bypass ? cfg_key_off  : tbl_off_q[head_idx];
        key_mask_d = bypass ? cfg_key_mask : tbl_mask_q[head_idx];
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_phv[wr_ptr_q] <= bus.phv_in;
      fifo_idx[wr_ptr_q] <= bus.vlan_in[KEY_OFF_ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      phv_out_q  <= '0;
      key_off_q  <= '0;
      key_mask_q <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < TBL_N; i++) begin
        tbl_off_q[i]  <= '0;
        tbl_mask_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      valid_q    <= valid_d;
      phv_out_q  <= phv_out_d;
      key_off_q  <= key_off_d;
      key_mask_q <= key_mask_d;
      overflow_q <= overflow_d;
      tbl_off_q  <= tbl_off_d;
      tbl_mask_q <= tbl_mask_d;
    end
  end

  assign bus.ready_out        = ready_out;
  assign bus.phv_out          = phv_out_q;
  assign bus.phv_valid_out    = valid_q;
  assign bus.key_offset_valid = valid_q;
  assign bus.key_offset_w     = key_off_q;
  assign bus.key_mask_w       = key_mask_q;
  assign overflow_err         = overflow_q;
endmodule
